// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module  : ram_arb_pkg
// Brief   : Shared types and constants for the two-port RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  // Arbiter sequencing: IDLE waits for a request, ACCESS drives the RAM,
  // DATA returns the completion and may re-arbitrate.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2
  } state_e;

  // Requester indices into the packed req/we/lock/addr/wdata vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // Requester index to one-hot grant vector.
  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module  : ram_arbiter_if
// Brief   : Requester-side and RAM-side signals of the arbiter, bundled.
//           The slave modport is the arbiter; master is its environment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [1:0]          req;
  logic [1:0]          we;
  logic [1:0]          lock;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_data;
  logic                ram_wren;
  logic [DATA_W-1:0]   ram_q;
  logic                busy;

  modport master (
    output req, we, lock, addr, wdata, ram_q,
    input  gnt, done, rdata, ram_addr, ram_data, ram_wren, busy
  );

  modport slave (
    input  req, we, lock, addr, wdata, ram_q,
    output gnt, done, rdata, ram_addr, ram_data, ram_wren, busy
  );

endinterface

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
// Module  : arb_rr2
// Brief   : Two-requester round-robin winner select with lock override.
//           ptr_i is the index granted last; on contention the other wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       hold_i,
  input  logic       owner_i,
  output logic [1:0] win_o
);

  // A held lock pins the grant to the owner; otherwise plain round-robin.
  always_comb begin
    win_o = 2'b00;
    if (hold_i) begin
      win_o = idx2onehot(owner_i);
    end else begin
      case (req_i)
        2'b01:   win_o = 2'b01;
        2'b10:   win_o = 2'b10;
        2'b11:   win_o = idx2onehot(~ptr_i);
        default: win_o = 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module  : ram_arbiter
// Brief   : Arbitrates CPU (index 0) and DMA (index 1) access to one
//           single-port RAM. One access every two cycles: ACCESS drives the
//           RAM and pulses gnt, DATA pulses done with read data.
//           The RAM read data is captured at the edge that ends ACCESS.
//           Optional: RAM_ARB_LOCK_EN enables bus locking via the lock port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ram_arbiter_if.slave  bus
);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_vld_q, owner_vld_d;
  logic                owner_q, owner_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          win_q, win_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;

  logic                arb_en;
  logic                hold;
  logic [1:0]          win;
  logic                win_idx;

`ifdef RAM_ARB_LOCK_EN
  // The owner keeps the bus only while it still requests and still locks.
  assign hold = owner_vld_q & bus.req[owner_q] & bus.lock[owner_q];
`else
  logic unused_lock;
  assign hold        = 1'b0;
  assign unused_lock = ^{bus.lock, owner_vld_q, owner_q};
`endif

  arb_rr2 u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .hold_i  (hold),
    .owner_i (owner_q),
    .win_o   (win)
  );

  assign win_idx = win[REQ_DMA];

  // Next-state and registered-output decode; arbitration happens in IDLE/DATA.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    win_d       = win_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wren_d  = 1'b0;
    arb_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          arb_en  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DATA;
        done_d  = win_q;
        rdata_d = we_q ? '0 : bus.ram_q;
      end
      DATA: begin
        if (|bus.req) begin
          arb_en  = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_en) begin
      ptr_d      = win_idx;
      win_d      = win;
      gnt_d      = win;
      we_d       = bus.we[win_idx];
      ram_wren_d = bus.we[win_idx];
      ram_addr_d = win_idx ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
      ram_data_d = win_idx ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
`ifdef RAM_ARB_LOCK_EN
      owner_vld_d = bus.lock[win_idx];
      owner_d     = win_idx;
`else
      owner_vld_d = 1'b0;
      owner_d     = 1'b0;
`endif
    end
  end

  // State and output registers; reset lets the CPU win the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      win_q       <= 2'b00;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      win_q       <= win_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module  : tb_ram_arbiter
// Brief   : Self-checking bench for ram_arbiter: directed vectors, corner
//           sequences and a randomized run against a cycle-slot model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int NCYC = 1500;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // RAM attached to the arbiter; read data presented for the current address.
  logic [DW-1:0] mem [256];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign bus.ram_q = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] lk,
                       input logic [15:0] a, input logic [15:0] d);
    bus.req   = r;
    bus.we    = w;
    bus.lock  = lk;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  typedef struct {
    logic       who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] pre;
    logic [1:0] exp_gnt;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Randomized-run agents and reference model state.
  logic [1:0] pend;
  logic [1:0] p_we;
  logic [1:0] p_lock;
  logic [7:0] p_addr  [2];
  logic [7:0] p_wdata [2];
  logic [7:0] ref_mem [256];

  task automatic drive_agents();
    drive(pend, p_we, p_lock, {p_addr[1], p_addr[0]}, {p_wdata[1], p_wdata[0]});
  endtask

  initial begin
    logic [1:0]  eg, ed;
    logic [15:0] va, vd;
    int          last, next_arb, owner, w;
    logic        own_vld, hold;
    logic [1:0]  carry_done, exp_gnt, exp_done;
    logic [7:0]  carry_rd, exp_rd, exp_addr, exp_wd;
    logic        exp_wren;

    vecs[0] = '{who: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, pre: 8'hA5, exp_gnt: 2'b01, exp_rdata: 8'hA5};
    vecs[1] = '{who: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, pre: 8'h00, exp_gnt: 2'b10, exp_rdata: 8'h00};
    vecs[2] = '{who: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'hFF, pre: 8'h3C, exp_gnt: 2'b10, exp_rdata: 8'h3C};
    vecs[3] = '{who: 1'b0, we: 1'b1, addr: 8'hFF, wdata: 8'h5A, pre: 8'h12, exp_gnt: 2'b01, exp_rdata: 8'h00};
    vecs[4] = '{who: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, pre: 8'h81, exp_gnt: 2'b01, exp_rdata: 8'h81};
    vecs[5] = '{who: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, pre: 8'hC3, exp_gnt: 2'b10, exp_rdata: 8'hC3};

    // ---- Reset values, with both requesters already asking ----
    drive(2'b11, 2'b00, 2'b00, 16'h0201, 16'h0000);
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt",      32'(bus.gnt),      32'h0);
    check("rst_done",     32'(bus.done),     32'h0);
    check("rst_rdata",    32'(bus.rdata),    32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_data", 32'(bus.ram_data), 32'h0);
    check("rst_ram_wren", 32'(bus.ram_wren), 32'h0);
    check("rst_busy",     32'(bus.busy),     32'h0);
    #10 rst_n = 1'b1;

    // ---- Both held high from reset: CPU, DMA, CPU, DMA every 2 cycles ----
    for (int k = 0; k < 8; k++) begin
      step();
      eg = ((k % 2) == 0) ? (((k / 2) % 2) == 0 ? 2'b01 : 2'b10) : 2'b00;
      ed = ((k % 2) == 1) ? ((((k - 1) / 2) % 2) == 0 ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("rr_gnt_%0d", k),  32'(bus.gnt),  32'(eg));
      check($sformatf("rr_done_%0d", k), 32'(bus.done), 32'(ed));
      check($sformatf("rr_busy_%0d", k), 32'(bus.busy), 32'h1);
    end
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    step();
    check("rr_idle_busy", 32'(bus.busy), 32'h0);

    // ---- Table of single transactions ----
    for (int i = 0; i < 6; i++) begin
      preload(vecs[i].addr, vecs[i].pre);
      va = vecs[i].who ? {vecs[i].addr, ~vecs[i].addr} : {~vecs[i].addr, vecs[i].addr};
      vd = vecs[i].who ? {vecs[i].wdata, ~vecs[i].wdata} : {~vecs[i].wdata, vecs[i].wdata};
      drive(vecs[i].exp_gnt, {vecs[i].we, vecs[i].we}, 2'b00, va, vd);
      step();
      check($sformatf("v%0d_gnt", i),      32'(bus.gnt),      32'(vecs[i].exp_gnt));
      check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_ram_wren", i), 32'(bus.ram_wren), 32'(vecs[i].we));
      check($sformatf("v%0d_busy_a", i),   32'(bus.busy),     32'h1);
      check($sformatf("v%0d_done_a", i),   32'(bus.done),     32'h0);
      if (vecs[i].we) check($sformatf("v%0d_ram_data", i), 32'(bus.ram_data), 32'(vecs[i].wdata));
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
      step();
      check($sformatf("v%0d_gnt_d", i),    32'(bus.gnt),      32'h0);
      check($sformatf("v%0d_done", i),     32'(bus.done),     32'(vecs[i].exp_gnt));
      check($sformatf("v%0d_rdata", i),    32'(bus.rdata),    32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_wren_d", i),   32'(bus.ram_wren), 32'h0);
      check($sformatf("v%0d_busy_d", i),   32'(bus.busy),     32'h1);
      step();
      check($sformatf("v%0d_busy_i", i),   32'(bus.busy),     32'h0);
      check($sformatf("v%0d_done_i", i),   32'(bus.done),     32'h0);
      if (vecs[i].we) check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].addr]), 32'(vecs[i].wdata));
    end

    // ---- CPU request withdrawn before it is sampled ----
    #1 drive(2'b01, 2'b01, 2'b00, 16'h0033, 16'h0099);
    #3 drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("wd_gnt_%0d", k),  32'(bus.gnt),      32'h0);
      check($sformatf("wd_wren_%0d", k), 32'(bus.ram_wren), 32'h0);
      check($sformatf("wd_busy_%0d", k), 32'(bus.busy),     32'h0);
    end

    // ---- Reset pulsed during a DMA write ACCESS ----
    preload(8'h40, 8'h11);
    drive(2'b10, 2'b10, 2'b00, 16'h4000, 16'h7700);
    step();
    check("ar_gnt",  32'(bus.gnt),      32'h2);
    check("ar_wren", 32'(bus.ram_wren), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wren_drop", 32'(bus.ram_wren), 32'h0);
    check("ar_gnt_drop",  32'(bus.gnt),      32'h0);
    check("ar_busy_drop", 32'(bus.busy),     32'h0);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ar_done_%0d", k), 32'(bus.done), 32'h0);
      check($sformatf("ar_busy_%0d", k), 32'(bus.busy), 32'h0);
    end
    check("ar_mem", 32'(mem[8'h40]), 32'h11);

`ifdef RAM_ARB_LOCK_EN
    // ---- CPU locks for three accesses while DMA keeps asking ----
    drive(2'b11, 2'b00, 2'b01, 16'h0504, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      step();
      eg = ((k % 2) == 0) ? ((k < 6) ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("lk_gnt_%0d", k), 32'(bus.gnt), 32'(eg));
      if (k == 4) bus.lock = 2'b00;
    end
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    step();
    step();
    check("lk_idle_busy", 32'(bus.busy), 32'h0);
`endif

    // ---- Randomized traffic against a slot-based reference ----
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 8'($urandom);
      preload(8'(a), ref_mem[a]);
    end
    pend       = 2'b00;
    p_we       = 2'b00;
    p_lock     = 2'b00;
    p_addr[0]  = 8'h0; p_addr[1]  = 8'h0;
    p_wdata[0] = 8'h0; p_wdata[1] = 8'h0;
    last       = 1;
    next_arb   = 0;
    own_vld    = 1'b0;
    owner      = 0;
    carry_done = 2'b00;
    carry_rd   = 8'h00;

    for (int n = 0; n < NCYC; n++) begin
      if (n < NCYC - 20) begin
        for (int r = 0; r < 2; r++) begin
          if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
            pend[r]    = 1'b1;
            p_we[r]    = 1'($urandom_range(0, 1));
            p_lock[r]  = ($urandom_range(0, 3) == 0);
            p_addr[r]  = 8'($urandom_range(0, 15));
            p_wdata[r] = 8'($urandom);
          end
        end
      end
      drive_agents();

      exp_done   = carry_done;
      exp_rd     = carry_rd;
      carry_done = 2'b00;
      exp_gnt    = 2'b00;
      exp_wren   = 1'b0;
      exp_addr   = 8'h00;
      exp_wd     = 8'h00;
      w          = -1;
      if (n >= next_arb && pend != 2'b00) begin
`ifdef RAM_ARB_LOCK_EN
        hold = own_vld && pend[owner] && p_lock[owner];
`else
        hold = 1'b0;
`endif
        if (hold)                w = owner;
        else if (pend == 2'b11)  w = 1 - last;
        else                     w = pend[1] ? 1 : 0;
        exp_gnt  = (w == 1) ? 2'b10 : 2'b01;
        exp_wren = p_we[w];
        exp_addr = p_addr[w];
        exp_wd   = p_wdata[w];
        if (p_we[w]) begin
          ref_mem[p_addr[w]] = p_wdata[w];
          carry_rd = 8'h00;
        end else begin
          carry_rd = ref_mem[p_addr[w]];
        end
        carry_done = exp_gnt;
        next_arb   = n + 2;
        last       = w;
        own_vld    = p_lock[w];
        owner      = w;
      end

      step();
      check("rnd_gnt",  32'(bus.gnt),      32'(exp_gnt));
      check("rnd_done", 32'(bus.done),     32'(exp_done));
      check("rnd_wren", 32'(bus.ram_wren), 32'(exp_wren));
      check("rnd_busy", 32'(bus.busy),     32'(|{exp_gnt, exp_done}));
      if (exp_gnt != 2'b00) check("rnd_ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
      if (exp_wren)         check("rnd_ram_data", 32'(bus.ram_data), 32'(exp_wd));
      if (exp_done != 2'b00) check("rnd_rdata",   32'(bus.rdata),    32'(exp_rd));
      if (w >= 0) pend[w] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
